// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing and the bit-order helper
// used by the rx/tx path blocks.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_CYCLES_PER_BIT = 10416;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Swap bit order: bit 0 becomes bit 7 and so on.
  function automatic uart_byte_t bit_reverse8(input uart_byte_t d);
    uart_byte_t r;
    for (int i = 0; i < UART_DATA_W; i++) begin
      r[i] = d[UART_DATA_W-1-i];
    end
    return r;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the core.
// Captures one byte per rising edge of rx_send, optionally fixing bit order,
// and drops bytes with a sticky overflow flag only when truly full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,  // power of two, >= 2
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_send,
  input  logic [UART_DATA_W-1:0]     rx_data,
  output logic [UART_DATA_W-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Storage and control state
  uart_byte_t       mem_q [DEPTH];
  logic             send_q,     send_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             full_q,     full_d;
  logic             valid_q,    valid_d;
  logic             overflow_q, overflow_d;

  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  uart_byte_t wr_byte;

  // Next-state logic: edge detect, push/pop arbitration, pointers, flags
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    send_d     = rx_send;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    push_req   = rx_send & ~send_q;
    pop        = valid_q & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = push_req & (~full_q | pop);
    drop       = push_req & full_q & ~pop;
    wr_byte    = BIT_REVERSE ? bit_reverse8(rx_data) : rx_data;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d     = (count_d == CNT_W'(DEPTH));
    valid_d    = (count_d != '0);
    // Set wins over a simultaneous clear so a drop is never hidden.
    overflow_d = drop | (overflow_q & ~ovf_clear);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      send_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      send_q     <= send_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage write port
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; pointers and count define which entries
    // are live, and leaving it unreset lets it map onto distributed RAM.
    if (push) mem_q[wr_ptr_q] <= wr_byte;
  end

  // Outputs: head byte is masked to zero while the FIFO is empty
  always_comb begin
    out_data  = valid_q ? mem_q[rd_ptr_q] : '0;
    out_valid = valid_q;
    count     = count_q;
    full      = full_q;
    overflow  = overflow_q;
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, BIT_REVERSE 1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_send;
  logic [7:0] rx_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       ovf_clear;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.DEPTH(16), .BIT_REVERSE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_send   (rx_send),
    .rx_data   (rx_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by an idle cycle so the next strobe is an edge.
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_send = 1'b1;
    step();
    rx_send = 1'b0;
    step();
  endtask

  logic [7:0] exp_q[$];
  int         got;

  initial begin
    rst = 1'b1; rx_send = 1'b0; rx_data = 8'h00; out_ready = 1'b0; ovf_clear = 1'b0;
    step(); step();

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_count", 32'(count),     32'd0);
    check("rst_full",  32'(full),      32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);

    // Strobe in the first cycle out of reset; 8'h82 stored as 8'h41
    rst = 1'b0; rx_data = 8'h82; rx_send = 1'b1;
    step();
    rx_send = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'h41);
    check("t1_count", 32'(count),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_pop_valid", 32'(out_valid), 32'd0);
    check("t1_pop_count", 32'(count),     32'd0);
    check("t1_pop_data",  32'(out_data),  32'h00);

    // Long strobe pushes exactly once; 8'h55 reversed is 8'hAA
    rx_data = 8'h55; rx_send = 1'b1;
    repeat (5) step();
    rx_send = 1'b0;
    step();
    check("hold_count", 32'(count),    32'd1);
    check("hold_data",  32'(out_data), 32'hAA);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("hold_drain", 32'(count), 32'd0);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf0",  32'(overflow), 32'd0);
    push_byte(8'hFF);
    check("drop_ovf",   32'(overflow), 32'd1);
    check("drop_count", 32'(count),    32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_data%0d", i), 32'(out_data), 32'(rev8(8'(i))));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_ovf",   32'(overflow),  32'd1);
    ovf_clear = 1'b1; step(); ovf_clear = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle reuses the freed slot
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    check("full2", 32'(full), 32'd1);
    rx_data = 8'hAA; rx_send = 1'b1; out_ready = 1'b1;
    step();
    rx_send = 1'b0; out_ready = 1'b0;
    check("pp_count", 32'(count),    32'd16);
    check("pp_ovf",   32'(overflow), 32'd0);
    check("pp_full",  32'(full),     32'd1);
    step();
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("pp_data%0d", i), 32'(out_data), 32'(rev8(8'(8'h10 + i))));
      step();
    end
    check("pp_last", 32'(out_data), 32'h55);
    step();
    check("pp_empty", 32'(out_valid), 32'd0);

    // Streaming with continuous pop: order preserved, occupancy stays small
    got = 0;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(8'h30 + i);
      exp_q.push_back(rev8(rx_data));
      for (int ph = 0; ph < 2; ph++) begin
        rx_send = (ph == 0);
        step();
        if (count > 5'd2) check("stream_count", 32'(count), 32'd2);
        if (out_valid) begin
          if (exp_q.size() == 0) check("stream_extra", 32'(out_data), 32'hFFFF);
          else begin
            check($sformatf("stream%0d", got), 32'(out_data), 32'(exp_q.pop_front()));
            got++;
          end
        end
      end
    end
    rx_send = 1'b0;
    check("stream_total", 32'(got), 32'd20);
    out_ready = 1'b0;

    // Reset discards stored bytes
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    check("prerst_count", 32'(count), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_count", 32'(count),     32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    push_byte(8'h01);
    check("postrst_data",  32'(out_data), 32'h80);
    check("postrst_count", 32'(count),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
